// File: rtl/input_conditioner.sv
// input_conditioner
//   Conditions raw, bouncing board inputs (buttons, switches) for the datapath.
//   Each channel has a 2-FF synchronizer and a debounce FSM with a
//   consecutive-sample counter. The outputs are a clean level plus one-cycle
//   rise and fall strobes. Channels are fully independent.
module input_conditioner #(
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level_out,
  output logic [N_IN-1:0] rise_pulse,
  output logic [N_IN-1:0] fall_pulse
);

  typedef enum logic [1:0] {
    STABLE_LO,
    CONFIRM_HI,
    STABLE_HI,
    CONFIRM_LO
  } state_e;

  // Terminal count: this is the last confirm sample before a change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // With a single-sample debounce, the confirm states are skipped entirely.
  localparam bit               ACCEPT_NOW = (DEBOUNCE_CYCLES == 1);

  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync2_q;

  // Two-stage synchronizer: only sync2_q is ever seen by the debounce logic.
  always_ff @(posedge sysclk) begin
    // NOTE: all clocked state uses non-blocking assignment, so that every
    // register samples the pre-edge values of its inputs.
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < N_IN; ch++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Debounce FSM: accept a new level after DEBOUNCE_CYCLES consecutive mismatched samples.
    always_ff @(posedge sysclk) begin
      if (reset) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        // NOTE: the strobes default low every cycle. Only an acceptance raises
        // them, so each strobe lasts exactly one cycle.
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        unique case (state_q)
          STABLE_LO: begin
            if (sync2_q[ch]) begin
              if (ACCEPT_NOW) begin
                state_q <= STABLE_HI;
                cnt_q   <= '0;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state_q <= CONFIRM_HI;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          CONFIRM_HI: begin
            if (!sync2_q[ch]) begin
              // A single sample back at the stable value discards the partial confirm.
              state_q <= STABLE_LO;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          STABLE_HI: begin
            if (!sync2_q[ch]) begin
              if (ACCEPT_NOW) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                state_q <= CONFIRM_LO;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          CONFIRM_LO: begin
            if (sync2_q[ch]) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign level_out[ch]  = level_q;
    assign rise_pulse[ch] = rise_q;
    assign fall_pulse[ch] = fall_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed stimulus with a cycle-stamped scoreboard. The stimulus process
//   pushes the expected {level, rise, fall} for a given clock edge. The monitor
//   samples on every falling edge and pops the entries that are due. Any strobe
//   on a cycle with no expectation is flagged.
module tb_input_conditioner;

  localparam int N_IN = 2;
  localparam int DEB  = 4;

  logic            sysclk = 1'b0;
  logic            reset;
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] level_out;
  logic [N_IN-1:0] rise_pulse;
  logic [N_IN-1:0] fall_pulse;

  input_conditioner #(
    .N_IN           (N_IN),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 sysclk = ~sysclk;

  // The edge counter holds the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [1:0] lvl,
                      input logic [1:0] rise, input logic [1:0] fall);
    exp_t e;
    e.cyc  = c;
    e.tag  = tag;
    e.lvl  = lvl;
    e.rise = rise;
    e.fall = fall;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  // Monitor: pops the entries that are due and checks for stray strobes.
  always @(negedge sysclk) begin
    if (mon_en) begin
      automatic bit matched = 1'b0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        automatic exp_t e = sb.pop_front();
        if (e.cyc < cyc) begin
          check({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
        end else begin
          check(e.tag, {26'd0, level_out, rise_pulse, fall_pulse},
                {26'd0, e.lvl, e.rise, e.fall});
          matched = 1'b1;
        end
      end
      if (!matched) check("no_stray_pulse", {28'd0, rise_pulse, fall_pulse}, 32'd0);
    end
  end

  initial begin
    reset  = 1'b1;
    raw_in = 2'b00;

    // Test 1: reset is held for three edges with the inputs low.
    wait_to(1);
    mon_en = 1'b1;
    push(2, "reset_state_a", 2'b00, 2'b00, 2'b00);
    push(3, "reset_state_b", 2'b00, 2'b00, 2'b00);
    push(5, "idle_after_reset", 2'b00, 2'b00, 2'b00);
    wait_to(3);
    reset = 1'b0;

    // Test 2: channel 0 rises. It is accepted on edge 6 and the strobe is gone on edge 7.
    wait_to(5);
    raw_in = 2'b01;
    push(10, "rise0_not_yet", 2'b00, 2'b00, 2'b00);
    push(11, "rise0_accept", 2'b01, 2'b01, 2'b00);
    push(12, "rise0_pulse_end", 2'b01, 2'b00, 2'b00);

    // Test 4a: a three-cycle drop from level 1 is only a glitch, so no fall is produced.
    wait_to(14);
    raw_in = 2'b00;
    wait_to(17);
    raw_in = 2'b01;
    push(20, "drop3_no_fall_a", 2'b01, 2'b00, 2'b00);
    push(22, "drop3_no_fall_b", 2'b01, 2'b00, 2'b00);

    // Test 4b: a held drop falls on edge 6.
    wait_to(23);
    raw_in = 2'b00;
    push(28, "fall0_not_yet", 2'b01, 2'b00, 2'b00);
    push(29, "fall0_accept", 2'b00, 2'b00, 2'b01);
    push(30, "fall0_pulse_end", 2'b00, 2'b00, 2'b00);

    // Test 3: one-cycle toggles, then held low, produce no change.
    wait_to(32);
    raw_in = 2'b01;
    wait_to(33);
    raw_in = 2'b00;
    wait_to(34);
    raw_in = 2'b01;
    wait_to(35);
    raw_in = 2'b00;
    push(40, "toggle_no_change_a", 2'b00, 2'b00, 2'b00);
    push(44, "toggle_no_change_b", 2'b00, 2'b00, 2'b00);

    // Test 5: both channels rise together, then channel 1 alone falls.
    wait_to(46);
    raw_in = 2'b11;
    push(52, "rise_both", 2'b11, 2'b11, 2'b00);
    push(53, "rise_both_end", 2'b11, 2'b00, 2'b00);
    wait_to(56);
    raw_in = 2'b01;
    push(62, "fall1_only", 2'b01, 2'b00, 2'b10);
    push(63, "fall1_only_end", 2'b01, 2'b00, 2'b00);

    // Bring channel 0 back low before the reset tests.
    wait_to(66);
    raw_in = 2'b00;
    push(72, "fall0_again", 2'b00, 2'b00, 2'b01);

    // Test 6: reset arrives in the second cycle of a confirm. The input is then
    // held high and must rise 6 edges after reset release.
    wait_to(76);
    raw_in = 2'b01;
    wait_to(80);
    reset = 1'b1;
    push(81, "reset_mid_confirm_a", 2'b00, 2'b00, 2'b00);
    push(82, "reset_mid_confirm_b", 2'b00, 2'b00, 2'b00);
    wait_to(82);
    reset = 1'b0;
    push(87, "post_reset_not_yet", 2'b00, 2'b00, 2'b00);
    push(88, "post_reset_rise", 2'b01, 2'b01, 2'b00);

    // Reset during the strobe cycle drops everything. Held input rises again afterwards.
    wait_to(88);
    reset = 1'b1;
    push(89, "reset_mid_pulse", 2'b00, 2'b00, 2'b00);
    wait_to(89);
    reset = 1'b0;
    push(94, "second_rise_not_yet", 2'b00, 2'b00, 2'b00);
    push(95, "second_rise", 2'b01, 2'b01, 2'b00);
    push(96, "second_rise_end", 2'b01, 2'b00, 2'b00);

    wait_to(100);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
